// File: rtl/seq_mult_acc.sv
// Sequential radix-2 shift-add multiplier: one multiplier bit per clock, valid/ready on both sides.
// Define MULT_ACC_EN to add an acc_in port so the block computes acc_in + a*b (one Horner step).
module seq_mult_acc #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MULT_ACC_EN
    input  logic [2*WIDTH-1:0] acc_in,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    localparam int PW = 2 * WIDTH;
    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic            sign_q;
    logic [PW-1:0]   partial_q;
    logic [SW-1:0]   step_q;
    logic [PW-1:0]   result_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;
`ifdef MULT_ACC_EN
    logic [PW-1:0]   acc_q;
`endif

    logic            neg_a;
    logic            neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   partial_d;
    logic [PW-1:0]   product;
    logic [PW-1:0]   result_d;

    // Magnitudes fit in WIDTH unsigned bits: -2^(WIDTH-1) negates to 2^(WIDTH-1).
    always_comb begin
        neg_a     = (SIGNED != 1'b0) && a[WIDTH-1];
        neg_b     = (SIGNED != 1'b0) && b[WIDTH-1];
        mag_a     = neg_a ? -a : a;
        mag_b     = neg_b ? -b : b;
        addend    = mplier_q[0] ? (PW'(mcand_q) << step_q) : '0;
        partial_d = partial_q + addend;
        product   = sign_q ? -partial_d : partial_d;
`ifdef MULT_ACC_EN
        result_d  = product + acc_q;
`else
        result_d  = product;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            sign_q      <= 1'b0;
            partial_q   <= '0;
            step_q      <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MULT_ACC_EN
            acc_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        mcand_q    <= mag_a;
                        mplier_q   <= mag_b;
                        sign_q     <= neg_a ^ neg_b;
                        partial_q  <= '0;
                        step_q     <= '0;
`ifdef MULT_ACC_EN
                        acc_q      <= acc_in;
`endif
                        state_q    <= S_BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_BUSY: begin
                    partial_q <= partial_d;
                    mplier_q  <= mplier_q >> 1;
                    step_q    <= step_q + 1'b1;
                    // Last multiplier bit: fold in sign and addend, publish the result.
                    if (step_q == SW'(WIDTH - 1)) begin
                        result_q    <= result_d;
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule
